// File: rtl/f8_fetch_queue_if.sv
// f8_fetch_queue_if
//   Bundles the prefetch stage's ROM-side and decoder-side signals.
//   slave  : the fetch queue (drives ROM addresses and decoder outputs).
//   master : the surroundings (ROM data, redirect, consume).
//
//   read_addr_even/odd  15  ROM word addresses
//   read_data_even/odd   8  ROM bytes, one cycle after the address
//   redirect / redirect_addr  flush and restart fetch at a new PC
//   consume              3  bytes taken by the decoder this cycle (0..4)
//   avail                4  valid bytes held
//   out_data            32  head bytes, [7:0] is the byte at out_pc
//   out_pc              16  address of out_data[7:0]
//   fetch_fault          1  fetch stopped at the ROM range boundary
interface f8_fetch_queue_if;
    logic [14:0] read_addr_even;
    logic [14:0] read_addr_odd;
    logic [7:0]  read_data_even;
    logic [7:0]  read_data_odd;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [2:0]  consume;
    logic [3:0]  avail;
    logic [31:0] out_data;
    logic [15:0] out_pc;
    logic        fetch_fault;

    modport slave (
        output read_addr_even, read_addr_odd,
        input  read_data_even, read_data_odd,
        input  redirect, redirect_addr, consume,
        output avail, out_data, out_pc, fetch_fault
    );

    modport master (
        input  read_addr_even, read_addr_odd,
        output read_data_even, read_data_odd,
        output redirect, redirect_addr, consume,
        input  avail, out_data, out_pc, fetch_fault
    );
endinterface

// File: rtl/f8_fetch_queue.sv
// f8_fetch_queue
//   Instruction prefetch stage in front of a dual-port even/odd byte ROM with
//   a 1-cycle registered read. Each issue requests two consecutive bytes
//   starting at fetch_addr; the response is pushed into a byte FIFO one cycle
//   later and the decoder sees up to 4 head bytes with their PC.
//
//   Ports:
//     clk    clock, all state on posedge
//     reset  synchronous, active-high
//     bus    f8_fetch_queue_if.slave (ROM address/data, redirect, consume,
//            avail, out_data, out_pc, fetch_fault)
//
//   Parameters:
//     DEPTH         byte FIFO capacity, power of two, >= 4
//     RESET_VECTOR  fetch and output PC after reset
//     ROMBASE       first valid ROM byte address (range check only)
//     ROMSIZE       ROM size in bytes (range check only)
//
//   Optional feature: define F8_FETCH_RANGE_CHECK_EN to stop fetching (and
//   raise a sticky fetch_fault) when a request would leave
//   [ROMBASE, ROMBASE+ROMSIZE). Without it fetch wraps mod 2^16 and
//   fetch_fault is 0.
module f8_fetch_queue #(
    parameter int          DEPTH        = 8,
    parameter logic [15:0] RESET_VECTOR = 16'h4000,
    parameter logic [15:0] ROMBASE      = 16'h4000,
    parameter int          ROMSIZE      = 2048
) (
    input  logic            clk,
    input  logic            reset,
    f8_fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // An issue needs room for both bytes of its response on top of what is
    // held and what is already in flight.
    localparam logic [CW+1:0] ISSUE_LIMIT = (CW+2)'(DEPTH - 2);

    logic [15:0]   fetch_addr_reg;
    logic [15:0]   out_pc_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          inflight_reg;
    logic          inflight_odd_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [14:0]   addr_even_reg;
    logic [14:0]   addr_odd_reg;

    logic          fetch_stop;
    logic          issue;
    logic          push;
    logic [CW+1:0] reserved;
    logic [14:0]   issue_word;
    logic [14:0]   issue_even;
    logic [CW-1:0] consume_ext;
    logic [CW-1:0] consume_eff;
    logic [7:0]    first_byte;
    logic [7:0]    second_byte;
    logic [PW-1:0] wr_ptr_inc;
    logic [7:0]    entry [DEPTH];

    // ------------------------------------------------------------------
    // Optional ROM range check
    // ------------------------------------------------------------------
`ifdef F8_FETCH_RANGE_CHECK_EN
    localparam logic [31:0] RANGE_LO = 32'(ROMBASE);
    localparam logic [31:0] RANGE_HI = 32'(ROMBASE) + 32'(ROMSIZE);

    logic out_of_range;
    logic fault_reg;

    // Both bytes of the pair must be inside the ROM; the 32-bit compare
    // keeps FFFF+1 from wrapping back into range.
    assign out_of_range = ({16'd0, fetch_addr_reg} < RANGE_LO) ||
                          (({16'd0, fetch_addr_reg} + 32'd1) >= RANGE_HI);
    assign fetch_stop   = fault_reg || out_of_range;

    always_ff @(posedge clk) begin
        if (reset || bus.redirect) begin
            fault_reg <= 1'b0;
        end else if (out_of_range) begin
            fault_reg <= 1'b1;
        end
    end

    assign bus.fetch_fault = fault_reg;
`else
    // Range configuration has no effect in this build.
    logic unused_range_cfg;
    assign unused_range_cfg = ^{ROMBASE, 32'(ROMSIZE)};
    assign fetch_stop       = 1'b0;
    assign bus.fetch_fault  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Issue decision and ROM addressing
    // ------------------------------------------------------------------
    assign reserved   = {2'b00, count_reg} + (inflight_reg ? (CW+2)'(2) : '0);
    assign issue      = !reset && !bus.redirect && (reserved <= ISSUE_LIMIT) && !fetch_stop;
    assign issue_word = fetch_addr_reg[15:1];
    // Unaligned pair: odd byte of this word, even byte of the next word.
    assign issue_even = fetch_addr_reg[0] ? issue_word + 15'd1 : issue_word;

    // Addresses go out combinationally in the issue cycle so the ROM's
    // registered read returns data exactly one cycle later.
    assign bus.read_addr_even = issue ? issue_even : addr_even_reg;
    assign bus.read_addr_odd  = issue ? issue_word : addr_odd_reg;

    // ------------------------------------------------------------------
    // Push / pop bookkeeping
    // ------------------------------------------------------------------
    assign push        = inflight_reg && !bus.redirect;
    assign first_byte  = inflight_odd_reg ? bus.read_data_odd  : bus.read_data_even;
    assign second_byte = inflight_odd_reg ? bus.read_data_even : bus.read_data_odd;
    assign wr_ptr_inc  = wr_ptr_reg + PW'(1);

    assign consume_ext = CW'(bus.consume);
    assign consume_eff = (consume_ext > count_reg) ? count_reg : consume_ext;
    assign count_next  = count_reg - consume_eff + (push ? CW'(2) : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr_reg   <= RESET_VECTOR;
            out_pc_reg       <= RESET_VECTOR;
            count_reg        <= '0;
            inflight_reg     <= 1'b0;
            inflight_odd_reg <= 1'b0;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            addr_even_reg    <= RESET_VECTOR[15:1];
            addr_odd_reg     <= RESET_VECTOR[15:1];
        end else if (bus.redirect) begin
            // Flush: held bytes and any arriving response are dropped.
            fetch_addr_reg   <= bus.redirect_addr;
            out_pc_reg       <= bus.redirect_addr;
            count_reg        <= '0;
            inflight_reg     <= 1'b0;
            inflight_odd_reg <= 1'b0;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
        end else begin
            out_pc_reg   <= out_pc_reg + 16'(consume_eff);
            rd_ptr_reg   <= rd_ptr_reg + PW'(consume_eff);
            count_reg    <= count_next;
            inflight_reg <= issue;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(2);
            end
            if (issue) begin
                fetch_addr_reg   <= fetch_addr_reg + 16'd2;
                inflight_odd_reg <= fetch_addr_reg[0];
                addr_even_reg    <= issue_even;
                addr_odd_reg     <= issue_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte storage: each entry takes the first or second byte of a push.
    // Head bytes are read combinationally, so this is register storage.
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [7:0] byte_reg;
        always_ff @(posedge clk) begin
            if (push) begin
                if (wr_ptr_reg == PW'(gi)) begin
                    byte_reg <= first_byte;
                end else if (wr_ptr_inc == PW'(gi)) begin
                    byte_reg <= second_byte;
                end
            end
        end
        assign entry[gi] = byte_reg;
    end

    for (gi = 0; gi < 4; gi++) begin : g_head
        assign bus.out_data[8*gi +: 8] = entry[rd_ptr_reg + PW'(gi)];
    end

    assign bus.avail  = 4'(count_reg);
    assign bus.out_pc = out_pc_reg;
endmodule
